// File: rtl/bridge_pkg.sv
// Shared definitions for the SRAM-to-AXI bridge front end: size encodings,
// requester indices and the grant-lock state type.
package bridge_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam int REQ_INST = 0;
  localparam int REQ_DATA = 1;
  localparam int REQ_UNC  = 2;

  typedef enum logic {
    ARB_SCAN = 1'b0,
    ARB_LOCK = 1'b1
  } arb_state_e;

endpackage

// File: rtl/id_fifo.sv
// In-order FIFO of requester IDs for accepted-but-unanswered requests.
// Push is ignored when full and pop when empty, so callers may gate loosely.
module id_fifo
  import bridge_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int IDW   = 2
) (
  input  logic           aclk,
  input  logic           aresetn,
  input  logic           i_push,
  input  logic [IDW-1:0] i_push_id,
  input  logic           i_pop,
  output logic [IDW-1:0] o_head_id,
  output logic           o_full,
  output logic           o_empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [IDW-1:0] r_mem [DEPTH];
  logic [PW-1:0]  r_wr_ptr;
  logic [PW-1:0]  r_rd_ptr;
  logic [CW-1:0]  r_count;
  logic           w_do_push;
  logic           w_do_pop;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;
  assign o_head_id = r_mem[r_rd_ptr];

  // Storage is not reset; the count alone defines which entries are live.
  always_ff @(posedge aclk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_push_id;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/sram_req_arbiter.sv
// Round-robin arbiter sharing one sram-like master port among NREQ requesters,
// with grant lock while waiting for addr_ok and in-order data_ok routing.
//
//   state    | meaning
//   ARB_SCAN | grant recomputed each cycle by round-robin scan after r_last
//   ARB_LOCK | grant pinned to r_cur until it is accepted or withdrawn
module sram_req_arbiter
  import bridge_pkg::*;
#(
  parameter int NREQ  = 3,
  parameter int DEPTH = 4,
  parameter int IDW   = $clog2(NREQ)
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic [NREQ-1:0]      m_req,
  input  logic [NREQ-1:0]      m_wr,
  input  logic [2*NREQ-1:0]    m_size,
  input  logic [32*NREQ-1:0]   m_addr,
  input  logic [4*NREQ-1:0]    m_wstrb,
  input  logic [32*NREQ-1:0]   m_wdata,
  output logic [NREQ-1:0]      m_addr_ok,
  output logic [NREQ-1:0]      m_data_ok,
  output logic [31:0]          m_rdata,
  output logic                 s_req,
  output logic                 s_wr,
  output logic [1:0]           s_size,
  output logic [31:0]          s_addr,
  output logic [3:0]           s_wstrb,
  output logic [31:0]          s_wdata,
  input  logic                 s_addr_ok,
  input  logic                 s_data_ok,
  input  logic [31:0]          s_rdata,
  output logic                 err_unexp
);

  arb_state_e     r_state;
  arb_state_e     w_state_nxt;
  logic [IDW-1:0] r_cur;
  logic [IDW-1:0] w_cur_nxt;
  logic [IDW-1:0] r_last;
  logic [IDW-1:0] w_last_nxt;
  logic           r_err;

  logic [IDW-1:0] w_g;
  logic           w_accept;
  logic           w_pop;
  logic [IDW-1:0] w_head;
  logic           w_full;
  logic           w_empty;

  // First requester after `last` in circular order; falls back to `last`
  // when nobody requests, which is harmless because s_req is then low.
  function automatic logic [IDW-1:0] rr_pick(input logic [NREQ-1:0] req,
                                             input logic [IDW-1:0]  last);
    logic [IDW-1:0] pick;
    int             idx;
    pick = last;
    for (int k = NREQ; k >= 1; k--) begin
      idx = (int'(last) + k) % NREQ;
      if (req[idx]) begin
        pick = IDW'(idx);
      end
    end
    return pick;
  endfunction

  always_comb begin
    w_g = (r_state == ARB_LOCK) ? r_cur : rr_pick(m_req, r_last);
  end

  // A full FIFO blocks the request even if a pop lands in the same cycle.
  assign s_req    = m_req[w_g] & ~w_full & ((r_state == ARB_LOCK) | (|m_req));
  assign w_accept = s_req & s_addr_ok;
  assign w_pop    = s_data_ok & ~w_empty;

  always_comb begin
    s_wr    = 1'b0;
    s_size  = '0;
    s_addr  = '0;
    s_wstrb = '0;
    s_wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_g == IDW'(i)) begin
        s_wr    = m_wr[i];
        s_size  = m_size[2*i +: 2];
        s_addr  = m_addr[32*i +: 32];
        s_wstrb = m_wstrb[4*i +: 4];
        s_wdata = m_wdata[32*i +: 32];
      end
    end
  end

  always_comb begin
    m_addr_ok = '0;
    m_data_ok = '0;
    for (int i = 0; i < NREQ; i++) begin
      m_addr_ok[i] = w_accept & (w_g == IDW'(i));
      m_data_ok[i] = w_pop & (w_head == IDW'(i));
    end
  end

  assign m_rdata   = s_rdata;
  assign err_unexp = r_err;

  always_comb begin
    w_state_nxt = r_state;
    w_cur_nxt   = r_cur;
    w_last_nxt  = r_last;
    if (w_accept) begin
      w_state_nxt = ARB_SCAN;
      w_last_nxt  = w_g;
    end else if (s_req) begin
      w_state_nxt = ARB_LOCK;
      w_cur_nxt   = w_g;
    end else if ((r_state == ARB_LOCK) && !m_req[r_cur]) begin
      w_state_nxt = ARB_SCAN;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state <= ARB_SCAN;
      r_cur   <= '0;
      r_last  <= IDW'(NREQ - 1);
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cur   <= w_cur_nxt;
      r_last  <= w_last_nxt;
      if (s_data_ok && w_empty) begin
        r_err <= 1'b1;
      end
    end
  end

  id_fifo #(
    .DEPTH (DEPTH),
    .IDW   (IDW)
  ) u_id_fifo (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .i_push    (w_accept),
    .i_push_id (w_g),
    .i_pop     (w_pop),
    .o_head_id (w_head),
    .o_full    (w_full),
    .o_empty   (w_empty)
  );

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Self-checking bench for sram_req_arbiter: directed vector table, hand-written
// lock/cancel/unexpected sequences, and randomized traffic against a queue model.
module tb_sram_req_arbiter;

  localparam int NREQ  = 3;
  localparam int DEPTH = 4;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [2:0]  m_req, m_wr;
  logic [5:0]  m_size;
  logic [95:0] m_addr, m_wdata;
  logic [11:0] m_wstrb;
  logic [2:0]  m_addr_ok, m_data_ok;
  logic [31:0] m_rdata;
  logic        s_req, s_wr;
  logic [1:0]  s_size;
  logic [31:0] s_addr, s_wdata;
  logic [3:0]  s_wstrb;
  logic        s_addr_ok, s_data_ok;
  logic [31:0] s_rdata;
  logic        err_unexp;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 aclk = ~aclk;

  sram_req_arbiter #(.NREQ(NREQ), .DEPTH(DEPTH)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_addr(m_addr),
    .m_wstrb(m_wstrb), .m_wdata(m_wdata),
    .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata),
    .s_req(s_req), .s_wr(s_wr), .s_size(s_size), .s_addr(s_addr),
    .s_wstrb(s_wstrb), .s_wdata(s_wdata),
    .s_addr_ok(s_addr_ok), .s_data_ok(s_data_ok), .s_rdata(s_rdata),
    .err_unexp(err_unexp)
  );

  // ---------------- behavioural reference ----------------
  int mdl_q[$];
  int mdl_last, mdl_cur;
  bit mdl_locked, mdl_err;

  function automatic void mdl_reset();
    mdl_q.delete();
    mdl_last   = NREQ - 1;
    mdl_cur    = 0;
    mdl_locked = 0;
    mdl_err    = 0;
  endfunction

  function automatic int mdl_grant(input logic [2:0] req);
    if (mdl_locked) return mdl_cur;
    for (int k = 1; k <= NREQ; k++)
      if (req[(mdl_last + k) % NREQ]) return (mdl_last + k) % NREQ;
    return -1;
  endfunction

  function automatic logic [31:0] base_addr(input int i);
    return 32'h1000_0000 + 32'(i) * 32'h100;
  endfunction

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic drive(input logic [2:0] req, input logic aok, input logic dok,
                       input logic [31:0] rdata);
    m_req     = req;
    s_addr_ok = aok;
    s_data_ok = dok;
    s_rdata   = rdata;
    #1;
  endtask

  task automatic set_slices();
    m_wr = '0;
    for (int i = 0; i < NREQ; i++) begin
      m_size[2*i +: 2]   = 2'd2;
      m_addr[32*i +: 32] = base_addr(i);
      m_wstrb[4*i +: 4]  = 4'hF;
      m_wdata[32*i +: 32] = 32'hA000_0000 + 32'(i);
    end
  endtask

  task automatic do_reset();
    aresetn   = 1'b0;
    m_req     = '0;
    s_addr_ok = 1'b0;
    s_data_ok = 1'b0;
    s_rdata   = '0;
    set_slices();
    tick();
    tick();
    aresetn = 1'b1;
    mdl_reset();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [2:0]  req;
    logic        aok;
    logic        dok;
    logic [31:0] rdata;
    logic        exp_sreq;
    int          exp_g;
    logic [2:0]  exp_aok;
    logic [2:0]  exp_dok;
    logic        exp_err;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(input logic [2:0] req, input logic aok, input logic dok,
                              input logic sreq, input int g, input logic [2:0] eaok,
                              input logic [2:0] edok, input logic eerr);
    vec_t v;
    v.req = req; v.aok = aok; v.dok = dok;
    v.rdata = 32'h5000_0000 + 32'(vt.size());
    v.exp_sreq = sreq; v.exp_g = g; v.exp_aok = eaok; v.exp_dok = edok; v.exp_err = eerr;
    return v;
  endfunction

  task automatic run_random(input int ncyc);
    int         g;
    logic       e_sreq;
    logic [2:0] e_aok, e_dok;
    bit         acc;
    for (int c = 0; c < ncyc; c++) begin
      if (c == ncyc / 2) do_reset();
      m_req = 3'($urandom_range(0, 7));
      for (int i = 0; i < NREQ; i++) begin
        m_wr[i]             = 1'($urandom_range(0, 1));
        m_size[2*i +: 2]    = 2'($urandom_range(0, 2));
        m_addr[32*i +: 32]  = $urandom;
        m_wstrb[4*i +: 4]   = 4'($urandom_range(0, 15));
        m_wdata[32*i +: 32] = $urandom;
      end
      s_addr_ok = 1'($urandom_range(0, 1));
      s_data_ok = (mdl_q.size() > 0) ? ($urandom_range(0, 9) < 4) : ($urandom_range(0, 39) == 0);
      s_rdata   = $urandom;
      #1;
      g      = mdl_grant(m_req);
      e_sreq = (g >= 0) && m_req[g] && (mdl_q.size() < DEPTH);
      e_aok  = (e_sreq && s_addr_ok) ? 3'(1 << g) : 3'b000;
      e_dok  = (s_data_ok && mdl_q.size() > 0) ? 3'(1 << mdl_q[0]) : 3'b000;
      chk($sformatf("rnd%0d_sreq", c), 64'(s_req), 64'(e_sreq));
      chk($sformatf("rnd%0d_addr_ok", c), 64'(m_addr_ok), 64'(e_aok));
      chk($sformatf("rnd%0d_data_ok", c), 64'(m_data_ok), 64'(e_dok));
      chk($sformatf("rnd%0d_err", c), 64'(err_unexp), 64'(mdl_err));
      if (e_dok != 0) chk($sformatf("rnd%0d_rdata", c), 64'(m_rdata), 64'(s_rdata));
      if (e_sreq) begin
        chk($sformatf("rnd%0d_addr", c), 64'(s_addr), 64'(m_addr[32*g +: 32]));
        chk($sformatf("rnd%0d_ctl", c), 64'({s_wr, s_size, s_wstrb}),
            64'({m_wr[g], m_size[2*g +: 2], m_wstrb[4*g +: 4]}));
        chk($sformatf("rnd%0d_wdata", c), 64'(s_wdata), 64'(m_wdata[32*g +: 32]));
      end
      acc = e_sreq && s_addr_ok;
      if (s_data_ok) begin
        if (mdl_q.size() > 0) void'(mdl_q.pop_front());
        else mdl_err = 1;
      end
      if (acc) begin
        mdl_q.push_back(g);
        mdl_last   = g;
        mdl_locked = 0;
      end else if (e_sreq) begin
        mdl_locked = 1;
        mdl_cur    = g;
      end else if (mdl_locked && !m_req[mdl_cur]) begin
        mdl_locked = 0;
      end
      tick();
    end
  endtask

  initial begin
    // Fairness, full-blocking, in-order return, then an unexpected completion.
    vt.push_back(mk(3'b111, 1, 0, 1, 0, 3'b001, 3'b000, 0));
    vt.push_back(mk(3'b111, 1, 0, 1, 1, 3'b010, 3'b000, 0));
    vt.push_back(mk(3'b111, 1, 0, 1, 2, 3'b100, 3'b000, 0));
    vt.push_back(mk(3'b111, 1, 0, 1, 0, 3'b001, 3'b000, 0));
    vt.push_back(mk(3'b111, 1, 0, 0, 0, 3'b000, 3'b000, 0));
    vt.push_back(mk(3'b111, 1, 1, 0, 0, 3'b000, 3'b001, 0));
    vt.push_back(mk(3'b111, 1, 0, 1, 1, 3'b010, 3'b000, 0));
    vt.push_back(mk(3'b000, 0, 1, 0, 0, 3'b000, 3'b010, 0));
    vt.push_back(mk(3'b000, 0, 1, 0, 0, 3'b000, 3'b100, 0));
    vt.push_back(mk(3'b000, 0, 1, 0, 0, 3'b000, 3'b001, 0));
    vt.push_back(mk(3'b000, 0, 1, 0, 0, 3'b000, 3'b010, 0));
    vt.push_back(mk(3'b000, 0, 0, 0, 0, 3'b000, 3'b000, 0));
    vt.push_back(mk(3'b000, 0, 1, 0, 0, 3'b000, 3'b000, 0));
    vt.push_back(mk(3'b000, 0, 0, 0, 0, 3'b000, 3'b000, 1));

    do_reset();
    #1;
    chk("reset_sreq", 64'(s_req), 64'(0));
    chk("reset_addr_ok", 64'(m_addr_ok), 64'(0));
    chk("reset_data_ok", 64'(m_data_ok), 64'(0));
    chk("reset_err", 64'(err_unexp), 64'(0));
    chk("reset_rdata", 64'(m_rdata), 64'(0));
    tick();

    for (int i = 0; i < vt.size(); i++) begin
      drive(vt[i].req, vt[i].aok, vt[i].dok, vt[i].rdata);
      chk($sformatf("tbl%0d_sreq", i), 64'(s_req), 64'(vt[i].exp_sreq));
      chk($sformatf("tbl%0d_addr_ok", i), 64'(m_addr_ok), 64'(vt[i].exp_aok));
      chk($sformatf("tbl%0d_data_ok", i), 64'(m_data_ok), 64'(vt[i].exp_dok));
      chk($sformatf("tbl%0d_err", i), 64'(err_unexp), 64'(vt[i].exp_err));
      if (vt[i].exp_sreq)
        chk($sformatf("tbl%0d_addr", i), 64'(s_addr), 64'(base_addr(vt[i].exp_g)));
      if (vt[i].dok)
        chk($sformatf("tbl%0d_rdata", i), 64'(m_rdata), 64'(vt[i].rdata));
      tick();
    end

    // Single requester read with completion two cycles after acceptance.
    do_reset();
    m_addr[32 +: 32] = 32'h1C00_0000;
    drive(3'b010, 1, 0, 0);
    chk("single_addr_ok", 64'(m_addr_ok), 64'(3'b010));
    chk("single_addr", 64'(s_addr), 64'(32'h1C00_0000));
    chk("single_wr", 64'(s_wr), 64'(0));
    tick();
    drive(3'b000, 0, 0, 0);
    chk("single_gap_data_ok", 64'(m_data_ok), 64'(0));
    tick();
    drive(3'b000, 0, 1, 32'hDEAD_BEEF);
    chk("single_data_ok", 64'(m_data_ok), 64'(3'b010));
    chk("single_rdata", 64'(m_rdata), 64'(32'hDEAD_BEEF));
    chk("single_err", 64'(err_unexp), 64'(0));
    tick();

    // Lock: req0 waits three cycles while req1 (next in rotation) asserts.
    do_reset();
    drive(3'b001, 1, 0, 0);
    chk("lock_pre_addr_ok", 64'(m_addr_ok), 64'(3'b001));
    tick();
    drive(3'b001, 0, 0, 0);
    chk("lock_wait_sreq", 64'(s_req), 64'(1));
    chk("lock_wait_addr_ok", 64'(m_addr_ok), 64'(0));
    tick();
    for (int k = 0; k < 3; k++) begin
      drive(3'b011, 0, 0, 0);
      chk($sformatf("lock_hold%0d_addr", k), 64'(s_addr), 64'(base_addr(0)));
      chk($sformatf("lock_hold%0d_addr_ok", k), 64'(m_addr_ok), 64'(0));
      tick();
    end
    drive(3'b011, 1, 0, 0);
    chk("lock_accept_addr_ok", 64'(m_addr_ok), 64'(3'b001));
    chk("lock_accept_addr", 64'(s_addr), 64'(base_addr(0)));
    tick();
    drive(3'b011, 1, 0, 0);
    chk("lock_next_addr_ok", 64'(m_addr_ok), 64'(3'b010));
    chk("lock_next_addr", 64'(s_addr), 64'(base_addr(1)));
    tick();

    // Cancel: locked req0 withdraws; nothing is pushed for it.
    do_reset();
    drive(3'b001, 1, 0, 0);
    tick();
    drive(3'b001, 0, 0, 0);
    tick();
    drive(3'b010, 0, 0, 0);
    chk("cancel_sreq", 64'(s_req), 64'(0));
    tick();
    drive(3'b010, 1, 0, 0);
    chk("cancel_regrant", 64'(m_addr_ok), 64'(3'b010));
    tick();
    drive(3'b000, 0, 1, 0);
    chk("cancel_ret0", 64'(m_data_ok), 64'(3'b001));
    tick();
    drive(3'b000, 0, 1, 0);
    chk("cancel_ret1", 64'(m_data_ok), 64'(3'b010));
    tick();
    drive(3'b000, 0, 1, 0);
    chk("cancel_ret_empty", 64'(m_data_ok), 64'(0));
    tick();
    drive(3'b000, 0, 0, 0);
    chk("cancel_err", 64'(err_unexp), 64'(1));
    tick();

    // Unexpected completion right after reset; flag is sticky until reset.
    do_reset();
    drive(3'b000, 0, 1, 32'h1234);
    chk("unexp_data_ok", 64'(m_data_ok), 64'(0));
    chk("unexp_err_same", 64'(err_unexp), 64'(0));
    tick();
    for (int k = 0; k < 3; k++) begin
      drive(3'b000, 0, 0, 0);
      chk($sformatf("unexp_sticky%0d", k), 64'(err_unexp), 64'(1));
      tick();
    end
    do_reset();
    #1;
    chk("unexp_cleared", 64'(err_unexp), 64'(0));

    do_reset();
    run_random(600);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_req_arbiter.md
# sram_req_arbiter

Shares the single sram-like master port of the SRAM-to-AXI bridge among NREQ requesters (inst fetch, data load/store, uncached/debug), so the bridge sees one in-order stream. Round-robin grant, a grant lock while a request waits for `addr_ok`, and an in-order outstanding-ID FIFO that routes each downstream `data_ok`/`rdata` back to the requester that issued it. Sits between the CPU-side sram-like masters and the bridge's data port.

## Interface
- NREQ, 3, number of upstream requesters (2..4); index 0 has tie priority after reset
- DEPTH, 4, maximum accepted-but-unanswered requests (power of 2, 2..8)
- IDW, $clog2(NREQ), width of a requester index
- aclk  in  1  clock; all state on rising edge
- aresetn  in  1  asynchronous, active-low reset
- m_req  in  NREQ  per-requester request
- m_wr  in  NREQ  per-requester write flag
- m_size  in  2*NREQ  per-requester size (0/1/2 = 1/2/4 bytes), slice i at [2i+1:2i]
- m_addr  in  32*NREQ  per-requester address
- m_wstrb  in  4*NREQ  per-requester byte strobes
- m_wdata  in  32*NREQ  per-requester write data
- m_addr_ok  out  NREQ  one-hot address acceptance
- m_data_ok  out  NREQ  one-hot completion
- m_rdata  out  32  read data, shared, valid with any m_data_ok bit
- s_req, s_wr, s_size[2], s_addr[32], s_wstrb[4], s_wdata[32]  out  downstream request to bridge
- s_addr_ok, s_data_ok  in  1  downstream handshakes
- s_rdata  in  32  downstream read data
- err_unexp  out  1  sticky: s_data_ok seen with empty FIFO

## Operation
- Registers: `last` (IDW, last accepted index), `locked` (1), `cur` (IDW), ID FIFO (DEPTH x IDW, rd/wr pointers, count of width $clog2(DEPTH+1)), `err_unexp`.
- Grant `g`: if `locked`, g = cur; else first i with m_req[i] set, scanning last+1, last+2, ... modulo NREQ.
- s_req = m_req[g] & (count != DEPTH) & (locked | (|m_req)). s_wr/s_size/s_addr/s_wstrb/s_wdata = slice g (don't-care when s_req=0).
- m_addr_ok[i] = s_req & s_addr_ok & (g == i), combinational.
- Accept (s_req & s_addr_ok): push g, last <= g, locked <= 0.
- Wait (s_req & !s_addr_ok): locked <= 1, cur <= g. No other requester can be granted until accept or cancel.
- Cancel (locked & !m_req[cur]): locked <= 0, no push, last unchanged; rescan next cycle.
- Completion (s_data_ok & count != 0): m_data_ok[head] = 1, pop; m_rdata = s_rdata always.
- s_data_ok with count == 0: no m_data_ok, err_unexp <= 1 (cleared only by reset).
- Full (count == DEPTH): s_req forced 0 even if a pop occurs the same cycle; lock is held (locked stays, cur stays).
- Push and pop in one cycle: count unchanged, both pointers advance modulo DEPTH.

## Timing
- Reset: locked=0, cur=0, last=NREQ-1, FIFO empty, err_unexp=0; hence all outputs 0.
- Zero-cycle forwarding: m_req -> s_req and s_addr_ok -> m_addr_ok/ s_data_ok -> m_data_ok are combinational; no added latency.
- Grant can change only on a cycle where locked=0; after an accept the next grant is evaluated in the following cycle.
- A request accepted in cycle N may complete in N+1 or later; completions return strictly in acceptance order.
- Reset mid-transaction discards FIFO contents; late s_data_ok after reset sets err_unexp.

## Structure
- Shared package `bridge_pkg`: size encodings (SZ_BYTE/SZ_HALF/SZ_WORD), requester index constants (REQ_INST=0, REQ_DATA=1, REQ_UNC=2).
- One sub-module: `id_fifo` (parameterised DEPTH x IDW, push/pop/full/empty/count, async active-low reset).
- Round-robin scan is a combinational function inside the top module.

## Test plan
- Single requester: m_req=3'b010 read addr 0x1C00_0000, s_addr_ok same cycle, s_data_ok 2 cycles later with s_rdata=0xDEAD_BEEF -> m_addr_ok=3'b010, m_data_ok=3'b010, m_rdata=0xDEAD_BEEF, err_unexp=0.
- Fairness: all three hold m_req=3'b111, s_addr_ok tied 1 -> accept order 0,1,2,0,1,2; FIFO returns IDs in same order.
- Lock: req0 waits with s_addr_ok=0 for 3 cycles while req1 asserts -> s_addr stays req0's address; req1 granted only the cycle after req0's accept.
- Cancel: req0 locked, then drops m_req -> no push, count unchanged, req1 granted next cycle.
- Full: 4 accepts with no s_data_ok -> s_req=0 on 5th; one s_data_ok -> m_data_ok to first ID, s_req reasserts next cycle.
- Unexpected: s_data_ok pulse after reset with empty FIFO -> m_data_ok=0, err_unexp=1 and sticky.
